// File: rtl/tx_frame_fifo.sv
// rtl/tx_frame_fifo.sv - frame-committed transmit FIFO; write-pointer checkpoint/rollback enabled by TX_FIFO_ROLLBACK_EN
module tx_frame_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int FRM_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_data_we,
    input  logic              i_push_write_index,
    input  logic              i_pop_write_index,
    input  logic              i_push_frame,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    input  logic              i_rd_ready,
    output logic              o_rd_last,
    output logic [ADDR_W:0]   o_data_size,
    output logic [FRM_W:0]    o_frames_count,
    output logic [7:0]        o_status
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int QDEPTH = 1 << FRM_W;

    typedef logic [ADDR_W:0] ptr_t;
    typedef logic [FRM_W:0]  cnt_t;

    logic [DATA_W-1:0] mem [DEPTH];
    ptr_t              q_len [QDEPTH];

    ptr_t wr_ptr, rd_ptr, frm_start, rd_cnt;
    cnt_t q_wp, q_rp;
    logic ovf, frm_ovf, rd_valid_q;

    logic data_full, q_full, we_ok, pop, store, commit, frm_ovf_set;
    logic rd_xfer, rd_last_w, last_xfer, valid_n;
    ptr_t wr_post, open_len, head_len, rollback_ptr;
    cnt_t q_wp_n, q_rp_n, count_n;

    assign o_data_size    = wr_ptr - rd_ptr;
    assign o_frames_count = q_wp - q_rp;
    assign data_full      = o_data_size[ADDR_W];
    assign q_full         = o_frames_count[FRM_W];

    // A same-cycle write is counted into the open frame before a commit.
    assign we_ok       = i_data_we & ~data_full;
    assign wr_post     = wr_ptr + ptr_t'(we_ok);
    assign open_len    = wr_post - frm_start;
    assign store       = we_ok & ~pop;
    assign commit      = ~pop & i_push_frame & (open_len != '0) & ~q_full;
    assign frm_ovf_set = ~pop & i_push_frame & (open_len != '0) & q_full;

`ifdef TX_FIFO_ROLLBACK_EN
    ptr_t chk_ptr;
    logic push_idx;

    assign pop          = i_pop_write_index;
    assign push_idx     = i_push_write_index & ~i_push_frame & ~i_pop_write_index;
    assign rollback_ptr = chk_ptr;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            chk_ptr <= '0;
        end else if (commit || push_idx) begin
            chk_ptr <= wr_post;
        end
    end
`else
    logic unused_rollback;

    assign unused_rollback = i_push_write_index ^ i_pop_write_index;
    assign pop             = 1'b0;
    assign rollback_ptr    = wr_ptr;
`endif

    assign head_len  = q_len[q_rp[FRM_W-1:0]];
    assign rd_xfer   = rd_valid_q & i_rd_ready;
    assign rd_last_w = (rd_cnt + ptr_t'(1'b1)) == head_len;
    assign last_xfer = rd_xfer & rd_last_w;
    assign q_wp_n    = q_wp + cnt_t'(commit);
    assign q_rp_n    = q_rp + cnt_t'(last_xfer);
    assign count_n   = q_wp_n - q_rp_n;

    // A frame must be counted for one full cycle before it is presented, but a
    // frame committed while the previous one drains keeps valid asserted.
    assign valid_n = (o_frames_count != '0) && (count_n != '0);

    always_ff @(posedge i_clk) begin
        if (i_rst_n && store) begin
            mem[wr_ptr[ADDR_W-1:0]] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n && commit) begin
            q_len[q_wp[FRM_W-1:0]] <= open_len;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            frm_start  <= '0;
            rd_cnt     <= '0;
            q_wp       <= '0;
            q_rp       <= '0;
            ovf        <= 1'b0;
            frm_ovf    <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr     <= pop ? rollback_ptr : wr_post;
            q_wp       <= q_wp_n;
            q_rp       <= q_rp_n;
            ovf        <= ovf | (i_data_we & data_full & ~pop);
            frm_ovf    <= frm_ovf | frm_ovf_set;
            rd_valid_q <= valid_n;
            if (commit) begin
                frm_start <= wr_post;
            end
            if (rd_xfer) begin
                rd_ptr <= rd_ptr + ptr_t'(1'b1);
                rd_cnt <= rd_last_w ? '0 : rd_cnt + ptr_t'(1'b1);
            end
        end
    end

    assign o_rd_data  = mem[rd_ptr[ADDR_W-1:0]];
    assign o_rd_valid = rd_valid_q;
    assign o_rd_last  = rd_valid_q & rd_last_w;
    assign o_status   = {1'b0, rd_valid_q, (wr_ptr != frm_start), frm_ovf, ovf,
                         q_full, data_full, (o_data_size == '0)};

endmodule
